cofre_controlador: RTL and testbench

//  Sequential controller for the safe's compare datapath (subtrator + comparador).
//  - Holds the stored password and registers each user attempt.
//  - Drives senha_atual/tentativa_reg into the datapath and samples its verdict (cmp_igual, cmp_perto).
//  - Counts failed attempts, enforces a timed lockout, drives led0/led1/led2 and the 7-seg display.

---
 rtl/cofre_pkg.sv | 46 ++++
 rtl/cofre_controlador_decodificador_7seg.sv | 19 +
 rtl/cofre_controlador.sv | 159 +++++++++++++++
 tb/tb_cofre_controlador.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cofre_pkg.sv
// Shared types and 7-segment constants for the safe controller.
package cofre_pkg;

  typedef enum logic [1:0] {
    OCIOSO,
    AVALIA,
    ABERTO,
    BLOQUEIO
  } estado_t;

  typedef enum logic [1:0] {
    MODO_DIGITO,
    MODO_ABERTO,
    MODO_BLOQUEIO
  } modo_t;

  // Active-low {dp,g,f,e,d,c,b,a}, dp kept dark
  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_A = 8'h88;
  localparam logic [7:0] SEG_B = 8'h83;

  localparam int unsigned DIFF_PERTO = 3;

  function automatic logic [7:0] seg_digito(input logic [2:0] v);
    logic [7:0] s;
    case (v)
      3'd0:    s = SEG_0;
      3'd1:    s = SEG_1;
      3'd2:    s = SEG_2;
      3'd3:    s = SEG_3;
      3'd4:    s = SEG_4;
      3'd5:    s = SEG_5;
      3'd6:    s = SEG_6;
      default: s = SEG_7;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/cofre_controlador_decodificador_7seg.sv
// Display decoder: digit, 'A' (open) or 'b' (locked); the parent registers the result.
module decodificador_7seg
  import cofre_pkg::*;
(
  input  logic [2:0] valor,
  input  modo_t      modo,
  output logic [7:0] seg
);

  always_comb begin
    seg = seg_digito(valor);
    case (modo)
      MODO_ABERTO:   seg = SEG_A;
      MODO_BLOQUEIO: seg = SEG_B;
      default:       seg = seg_digito(valor);
    endcase
  end

endmodule

// File: rtl/cofre_controlador.sv
// Safe controller: attempt capture, verdict sampling, failure count, timed lockout, LEDs/display.
// Optional password change enabled by defining COFRE_TROCA_SENHA_EN.
module cofre_controlador
  import cofre_pkg::*;
#(
  parameter int unsigned MAX_TENT      = 3,
  parameter int unsigned LOCK_CICLOS   = 100,
  parameter logic [3:0]  SENHA_INICIAL = 4'd7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       confirmar,
  input  logic       fechar,
  input  logic [3:0] tentativa,
`ifdef COFRE_TROCA_SENHA_EN
  input  logic [3:0] nova_senha,
  input  logic       gravar,
`endif
  input  logic       cmp_igual,
  input  logic       cmp_perto,
  output logic [3:0] senha_atual,
  output logic [3:0] tentativa_reg,
  output logic       led0,
  output logic       led1,
  output logic       led2,
  output logic       bloqueado,
  output logic [2:0] restantes,
  output logic [7:0] display
);

  localparam int unsigned TW   = $clog2(LOCK_CICLOS);
  localparam logic [2:0]  MAX3 = 3'(MAX_TENT);

  estado_t       estado, estado_next;
  logic [3:0]    tent_next;
  logic [2:0]    falhas, falhas_next;
  logic [TW-1:0] timer, timer_next;
  logic          led0_next, led1_next, led2_next, bloq_next;
  logic [2:0]    rest_next;
  modo_t         modo_next;
  logic [7:0]    display_next;

`ifdef COFRE_TROCA_SENHA_EN
  logic [3:0] senha, senha_next;

  always_comb begin
    senha_next = senha;
    if (estado == ABERTO && gravar) senha_next = nova_senha;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) senha <= SENHA_INICIAL;
    else     senha <= senha_next;
  end

  assign senha_atual = senha;
`else
  assign senha_atual = SENHA_INICIAL;
`endif

  // State register; every output is a flop loaded from its *_next value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado        <= OCIOSO;
      tentativa_reg <= '0;
      falhas        <= '0;
      timer         <= '0;
      led0          <= 1'b0;
      led1          <= 1'b0;
      led2          <= 1'b0;
      bloqueado     <= 1'b0;
      restantes     <= MAX3;
      display       <= seg_digito(MAX3);
    end else begin
      estado        <= estado_next;
      tentativa_reg <= tent_next;
      falhas        <= falhas_next;
      timer         <= timer_next;
      led0          <= led0_next;
      led1          <= led1_next;
      led2          <= led2_next;
      bloqueado     <= bloq_next;
      restantes     <= rest_next;
      display       <= display_next;
    end
  end

  always_comb begin
    estado_next = estado;
    tent_next   = tentativa_reg;
    falhas_next = falhas;
    timer_next  = timer;
    led0_next   = led0;
    led1_next   = led1;
    led2_next   = led2;
    case (estado)
      OCIOSO: begin
        if (confirmar) begin
          tent_next   = tentativa;
          led1_next   = 1'b0;
          led2_next   = 1'b0;
          estado_next = AVALIA;
        end
      end
      AVALIA: begin
        if (cmp_igual) begin
          falhas_next = '0;
          led0_next   = 1'b1;
          estado_next = ABERTO;
        end else begin
          led2_next   = 1'b1;
          led1_next   = cmp_perto;
          falhas_next = falhas + 3'd1;
          if (falhas + 3'd1 == MAX3) begin
            timer_next  = TW'(LOCK_CICLOS - 1);
            estado_next = BLOQUEIO;
          end else begin
            estado_next = OCIOSO;
          end
        end
      end
      ABERTO: begin
        if (fechar) begin
          led0_next   = 1'b0;
          estado_next = OCIOSO;
        end
      end
      BLOQUEIO: begin
        if (timer == '0) begin
          falhas_next = '0;
          led1_next   = 1'b0;
          led2_next   = 1'b0;
          estado_next = OCIOSO;
        end else begin
          timer_next = timer - TW'(1);
        end
      end
      default: estado_next = OCIOSO;
    endcase
  end

  // Outputs derived from the next state so they change on the same edge as the state
  always_comb begin
    bloq_next = (estado_next == BLOQUEIO);
    rest_next = (falhas_next >= MAX3) ? 3'd0 : MAX3 - falhas_next;
    case (estado_next)
      ABERTO:   modo_next = MODO_ABERTO;
      BLOQUEIO: modo_next = MODO_BLOQUEIO;
      default:  modo_next = MODO_DIGITO;
    endcase
  end

  decodificador_7seg u_dec (
    .valor (rest_next),
    .modo  (modo_next),
    .seg   (display_next)
  );

endmodule

// File: tb/tb_cofre_controlador.sv
// Scoreboard bench for cofre_controlador; includes the stand-in compare datapath.
module tb_cofre_controlador;
  import cofre_pkg::*;

  logic       clk = 1'b0;
  logic       rst, confirmar, fechar;
  logic [3:0] tentativa;
  logic       cmp_igual, cmp_perto;
  logic [3:0] senha_atual, tentativa_reg;
  logic       led0, led1, led2, bloqueado;
  logic [2:0] restantes;
  logic [7:0] display;
`ifdef COFRE_TROCA_SENHA_EN
  logic [3:0] nova_senha = 4'd0;
  logic       gravar = 1'b0;
`endif

  cofre_controlador #(.MAX_TENT(3), .LOCK_CICLOS(100), .SENHA_INICIAL(4'd7)) dut (
    .clk           (clk),
    .rst           (rst),
    .confirmar     (confirmar),
    .fechar        (fechar),
    .tentativa     (tentativa),
`ifdef COFRE_TROCA_SENHA_EN
    .nova_senha    (nova_senha),
    .gravar        (gravar),
`endif
    .cmp_igual     (cmp_igual),
    .cmp_perto     (cmp_perto),
    .senha_atual   (senha_atual),
    .tentativa_reg (tentativa_reg),
    .led0          (led0),
    .led1          (led1),
    .led2          (led2),
    .bloqueado     (bloqueado),
    .restantes     (restantes),
    .display       (display)
  );

  always #5 clk = ~clk;

  logic [3:0] dp_diff;
  always_comb begin
    dp_diff   = (senha_atual > tentativa_reg) ? senha_atual - tentativa_reg : tentativa_reg - senha_atual;
    cmp_igual = (dp_diff == 4'd0);
    cmp_perto = (dp_diff != 4'd0) && (dp_diff <= 4'(DIFF_PERTO));
  end

  // {led0,led1,led2,bloqueado,restantes,display}
  logic [14:0] obs;
  assign obs = {led0, led1, led2, bloqueado, restantes, display};

  logic [7:0]  seg_tab [0:7] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
  localparam logic [7:0]  EXP_A = 8'h88;
  localparam logic [7:0]  EXP_B = 8'h83;
  localparam logic [14:0] EXP_RESET = {4'b0000, 3'd3, 8'hB0};

  logic [14:0] sb [$];
  logic [14:0] exp_v;
  int          m_falhas;
  logic [3:0]  m_senha;
  int          n_checks, n_fail;

  function automatic logic [14:0] pack(input logic l0, input logic l1, input logic l2,
                                       input logic b, input int r, input logic [7:0] d);
    return {l0, l1, l2, b, 3'(r), d};
  endfunction

  task automatic attempt(input logic [3:0] t);
    logic [3:0] d;
    d = (t > m_senha) ? t - m_senha : m_senha - t;
    if (t == m_senha) begin
      m_falhas = 0;
      sb.push_back(pack(1'b1, 1'b0, 1'b0, 1'b0, 3, EXP_A));
    end else begin
      m_falhas++;
      if (m_falhas == 3)
        sb.push_back(pack(1'b0, d <= 4'd3, 1'b1, 1'b1, 0, EXP_B));
      else
        sb.push_back(pack(1'b0, d <= 4'd3, 1'b1, 1'b0, 3 - m_falhas, seg_tab[3 - m_falhas]));
    end
    @(negedge clk);
    tentativa = t;
    confirmar = 1'b1;
    @(negedge clk);
    confirmar = 1'b0;
    @(negedge clk);
  endtask

  task automatic close_safe();
    sb.push_back(pack(1'b0, 1'b0, 1'b0, 1'b0, 3 - m_falhas, seg_tab[3 - m_falhas]));
    @(negedge clk);
    fechar = 1'b1;
    @(negedge clk);
    fechar = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; confirmar = 1'b0; fechar = 1'b0; tentativa = 4'd0;
    m_falhas = 0; m_senha = 4'd7;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (obs !== EXP_RESET) begin n_fail++; $display("FAIL reset_outputs: got %h want %h", obs, EXP_RESET); end
    n_checks++;
    if ({senha_atual, tentativa_reg} !== 8'h70) begin
      n_fail++; $display("FAIL reset_regs: got senha=%0d tent=%0d want 7/0", senha_atual, tentativa_reg);
    end
  endtask

  task automatic test_open_close();
    attempt(4'd7);
    exp_v = sb.pop_front(); n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL open: got %h want %h", obs, exp_v); end
    close_safe();
    exp_v = sb.pop_front(); n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL close: got %h want %h", obs, exp_v); end
    attempt(4'd7);
    exp_v = sb.pop_front(); n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL reopen: got %h want %h", obs, exp_v); end
    // confirmar together with fechar: only the close may act
    sb.push_back(EXP_RESET);
    @(negedge clk);
    confirmar = 1'b1; fechar = 1'b1;
    @(negedge clk);
    confirmar = 1'b0; fechar = 1'b0;
    repeat (2) @(negedge clk);
    exp_v = sb.pop_front(); n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL confirm_fechar_same_cycle: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_wrong();
    attempt(4'd5);
    exp_v = sb.pop_front(); n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL wrong_near: got %h want %h", obs, exp_v); end
    attempt(4'd15);
    exp_v = sb.pop_front(); n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL wrong_far: got %h want %h", obs, exp_v); end
    n_checks++;
    if (tentativa_reg !== 4'd15) begin n_fail++; $display("FAIL tentativa_reg: got %0d want 15", tentativa_reg); end
    attempt(4'd7);
    exp_v = sb.pop_front(); n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL open_after_two_wrong: got %h want %h", obs, exp_v); end
    close_safe();
    exp_v = sb.pop_front(); n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL close_after_open: got %h want %h", obs, exp_v); end
    attempt(4'd5);
    exp_v = sb.pop_front(); n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL falhas_cleared: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_lockout();
    int cnt;
    attempt(4'd4);
    exp_v = sb.pop_front(); n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL lock_second_wrong: got %h want %h", obs, exp_v); end
    attempt(4'd12);
    exp_v = sb.pop_front(); n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL lock_enter: got %h want %h", obs, exp_v); end
    cnt = 0;
    while (bloqueado === 1'b1 && cnt < 200) begin
      if (display !== EXP_B && cnt < 100) begin
        n_checks++; n_fail++;
        $display("FAIL lock_display: got %h want %h at cycle %0d", display, EXP_B, cnt);
      end
      cnt++;
      tentativa = 4'd7;
      confirmar = (cnt == 10);
      @(negedge clk);
    end
    confirmar = 1'b0;
    n_checks++;
    if (cnt != 100) begin n_fail++; $display("FAIL lock_duration: got %0d cycles want 100", cnt); end
    m_falhas = 0;
    n_checks++;
    if (obs !== EXP_RESET) begin n_fail++; $display("FAIL lock_exit: got %h want %h", obs, EXP_RESET); end
    attempt(4'd5);
    exp_v = sb.pop_front(); n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL after_lock_attempt: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_reset_mid();
    attempt(4'd0);
    exp_v = sb.pop_front(); n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL pre_lock_wrong: got %h want %h", obs, exp_v); end
    attempt(4'd1);
    exp_v = sb.pop_front(); n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL pre_lock_enter: got %h want %h", obs, exp_v); end
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({obs, tentativa_reg} !== {EXP_RESET, 4'd0}) begin
      n_fail++; $display("FAIL rst_in_lockout: got %h/%0d want %h/0", obs, tentativa_reg, EXP_RESET);
    end
    @(negedge clk);
    rst = 1'b0; m_falhas = 0;
    @(negedge clk);
    tentativa = 4'd9; confirmar = 1'b1;
    @(negedge clk);
    confirmar = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({obs, tentativa_reg} !== {EXP_RESET, 4'd0}) begin
      n_fail++; $display("FAIL rst_in_avalia: got %h/%0d want %h/0", obs, tentativa_reg, EXP_RESET);
    end
    @(negedge clk);
    rst = 1'b0;
    attempt(4'd5);
    exp_v = sb.pop_front(); n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL after_rst_attempt: got %h want %h", obs, exp_v); end
  endtask

`ifdef COFRE_TROCA_SENHA_EN
  task automatic test_troca_senha();
    attempt(4'd7);
    exp_v = sb.pop_front(); n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL troca_open: got %h want %h", obs, exp_v); end
    sb.push_back(pack(1'b0, 1'b0, 1'b0, 1'b0, 3, seg_tab[3]));
    @(negedge clk);
    nova_senha = 4'd2; gravar = 1'b1; fechar = 1'b1;
    @(negedge clk);
    gravar = 1'b0; fechar = 1'b0;
    m_senha = 4'd2;
    exp_v = sb.pop_front(); n_checks++;
    if ({obs, senha_atual} !== {exp_v, m_senha}) begin
      n_fail++; $display("FAIL gravar_fechar: got %h/%0d want %h/%0d", obs, senha_atual, exp_v, m_senha);
    end
    attempt(4'd7);
    exp_v = sb.pop_front(); n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL old_senha_rejected: got %h want %h", obs, exp_v); end
    attempt(4'd2);
    exp_v = sb.pop_front(); n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL new_senha_opens: got %h want %h", obs, exp_v); end
    close_safe();
    exp_v = sb.pop_front();
    @(negedge clk);
    nova_senha = 4'd9; gravar = 1'b1;
    @(negedge clk);
    gravar = 1'b0;
    n_checks++;
    if ({obs, senha_atual} !== {exp_v, m_senha}) begin
      n_fail++; $display("FAIL gravar_in_ocioso: got %h/%0d want %h/%0d", obs, senha_atual, exp_v, m_senha);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_open_close();
    test_wrong();
    test_lockout();
    test_reset_mid();
`ifdef COFRE_TROCA_SENHA_EN
    test_troca_senha();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
